// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : RV32I instruction fetch stage. Holds the program counter,
//               issues word reads to instruction memory over a req/ack
//               handshake of arbitrary latency, and presents one fetched
//               instruction at a time (with its PC) to decode over a
//               valid/ready handshake. A redirect reloads the PC and squashes
//               any stale fetch or any instruction waiting for decode.
// Ports       :
//   clk             core clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   imem_req        fetch request to instruction memory
//   imem_addr       word-aligned fetch address
//   imem_ack        read complete, imem_rdata valid (only while imem_req=1)
//   imem_rdata      instruction word returned by memory
//   instr_valid     instr / instr_pc valid to decode
//   instr_ready     decode accepts instr this cycle
//   instr           fetched instruction
//   instr_pc        address of instr
//   redirect        load PC from redirect_target
//   redirect_target new PC, bits [1:0] ignored
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   // instruction memory
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   // decode
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   // control flow
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target
);

   localparam logic [31:0]     NOP        = 32'h0000_0013;
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

   // FETCH : request outstanding (or about to be raised right after reset)
   // HOLD  : instruction presented to decode, no memory traffic
   // DROP  : stale request outstanding, its data will be discarded
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;        // next address to fetch
   logic [XLEN-1:0] req_addr;  // address of the outstanding request
   logic [XLEN-1:0] target;    // aligned redirect target

   assign target    = redirect_target & ALIGN_MASK;
   assign imem_addr = req_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC_A;
         req_addr    <= RESET_PC_A;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= NOP;
         instr_pc    <= RESET_PC_A;
      end else begin
         case (state)
            FETCH: begin
               if (!imem_req) begin
                  // First cycle out of reset: nothing is outstanding yet, so
                  // a redirect can simply retarget the request before it is
                  // raised. Any ack seen now is not ours and is ignored.
                  imem_req <= 1'b1;
                  if (redirect) begin
                     pc       <= target;
                     req_addr <= target;
                  end
               end else if (redirect) begin
                  pc <= target;
                  if (imem_ack) begin
                     // Memory finished this cycle: drop the word and issue
                     // the new address straight away.
                     req_addr <= target;
                  end else begin
                     // The request cannot be withdrawn; let it complete on
                     // the old address and discard the result.
                     state <= DROP;
                  end
               end else if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_pc    <= req_addr;
                  pc          <= req_addr + PC_STEP;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end
            end

            HOLD: begin
               if (redirect) begin
                  // Squash the presented instruction even if decode is
                  // taking it this same cycle.
                  pc          <= target;
                  req_addr    <= target;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end else if (instr_ready) begin
                  req_addr    <= pc;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end
            end

            DROP: begin
               // Later redirects overwrite earlier ones; the most recent
               // target is the one fetched once the stale read drains.
               if (redirect) begin
                  pc <= target;
               end
               if (imem_ack) begin
                  req_addr <= redirect ? target : pc;
                  state    <= FETCH;
               end
            end

            default: begin
               state       <= FETCH;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. Directed scenarios with
//               exact expected values, followed by randomized memory latency,
//               decode back-pressure, redirects and resets checked against an
//               architectural model of the instruction stream (next expected
//               PC, memory contents as a function of address) plus handshake
//               rules. A second instance with RESET_PC=FFFF_FFFC checks wrap.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect;
   logic [31:0] redirect_target;

   // wrap-around instance: zero-wait memory, decode always ready
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic        w_redir;
   logic [31:0] w_tgt;

   int n_tests = 0;
   int n_fail  = 0;

   // memory contents: an injective function of the address
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
   endfunction

   assign w_ack   = w_req;
   assign w_rdata = word_of(w_addr);
   assign w_ready = 1'b1;
   assign w_redir = 1'b0;
   assign w_tgt   = 32'h0;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .redirect(redirect), .redirect_target(redirect_target)
   );

   instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
      .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr), .instr_pc(w_pc),
      .redirect(w_redir), .redirect_target(w_tgt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model controls
   int lat      = 1;   // request cycles up to and including the ack cycle
   int mem_wait = 0;   // cycles the current request has been waiting
   bit rnd_mem  = 1'b0;

   // architectural model
   logic [31:0] exp_pc = 32'h0;
   int          stall  = 0;

   // previous-cycle snapshot
   logic        p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0;
   logic        p_rdy = 1'b0, p_redir = 1'b0, p_rst = 1'b0;
   logic [31:0] p_addr = 32'h0, p_instr = 32'h0, p_pc = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock: memory responds and rules are checked at the falling edge,
   // the DUT updates at the rising edge, control returns 1 time unit later.
   task automatic cycle();
      @(negedge clk);
      if (!rst && imem_req)
         imem_ack = rnd_mem ? ($urandom_range(0, 1) == 1) : (mem_wait + 1 >= lat);
      else
         imem_ack = 1'b0;
      imem_rdata = word_of(imem_addr);

      if (p_rst) begin
         chkb("rst_req", imem_req, 1'b0);
         chkb("rst_valid", instr_valid, 1'b0);
         chk("rst_instr", instr, NOP);
         chk("rst_pc", instr_pc, 32'h0);
      end else begin
         if (p_req && !p_ack) begin
            chkb("req_held", imem_req, 1'b1);
            chk("addr_held", imem_addr, p_addr);
         end
         if (p_valid && !p_rdy && !p_redir) begin
            chkb("hold_valid", instr_valid, 1'b1);
            chk("hold_instr", instr, p_instr);
            chk("hold_pc", instr_pc, p_pc);
         end
         if (p_valid && (p_rdy || p_redir))
            chkb("valid_drop", instr_valid, 1'b0);
      end
      chkb("valid_and_req", instr_valid & imem_req, 1'b0);
      if (imem_req)
         chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);

      // architectural stream: what decode accepts must follow the program
      stall++;
      if (rst) begin
         exp_pc = 32'h0;
         stall  = 0;
      end else if (redirect) begin
         exp_pc = redirect_target & 32'hFFFF_FFFC;
      end else if (instr_valid && instr_ready) begin
         chk("accept_pc", instr_pc, exp_pc);
         chk("accept_instr", instr, word_of(exp_pc));
         exp_pc = exp_pc + 32'd4;
         stall  = 0;
      end
      if (stall > 200) begin
         chk("liveness_stall", 32'(stall), 32'd0);
         stall = 0;
      end

      p_req = imem_req;  p_ack = imem_ack;  p_valid = instr_valid;
      p_rdy = instr_ready; p_redir = redirect; p_rst = rst;
      p_addr = imem_addr; p_instr = instr;   p_pc = instr_pc;

      @(posedge clk);
      if (p_rst || !p_req || p_ack) mem_wait = 0;
      else                          mem_wait++;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      instr_ready = 1'b1;
      redirect = 1'b0;
      redirect_target = 32'h0;

      // ---- reset, zero-wait memory, decode always ready ----
      cycle();
      cycle();
      rst = 1'b0;
      chkb("r_req", imem_req, 1'b0);
      chkb("r_valid", instr_valid, 1'b0);
      chk("r_instr", instr, NOP);
      chk("r_pc", instr_pc, 32'h0);
      chk("r_addr", imem_addr, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         cycle();
         chkb("a_valid", instr_valid, (k % 2) == 0);
         chkb("a_req", imem_req, (k % 2) == 1);
         chkb("w_valid", w_valid, (k % 2) == 0);
         if ((k % 2) == 0) begin
            chk("a_pc", instr_pc, 32'((k / 2 - 1) * 4));
            chk("a_instr", instr, word_of(32'((k / 2 - 1) * 4)));
            chk("w_pc", w_pc, 32'hFFFF_FFFC + 32'((k / 2 - 1) * 4));
            chk("w_instr", w_instr, word_of(32'hFFFF_FFFC + 32'((k / 2 - 1) * 4)));
         end else begin
            chk("w_addr", w_addr, 32'hFFFF_FFFC + 32'(((k - 1) / 2) * 4));
         end
      end

      // ---- three-cycle memory latency ----
      lat = 3;
      cycle();
      for (int i = 0; i < 3; i++) begin
         chkb("l_req", imem_req, 1'b1);
         chk("l_addr", imem_addr, 32'h10);
         chkb("l_valid", instr_valid, 1'b0);
         cycle();
      end
      chkb("l_done", instr_valid, 1'b1);
      chk("l_pc", instr_pc, 32'h10);
      chk("l_instr", instr, word_of(32'h10));
      cycle();
      chk("l_next", imem_addr, 32'h14);

      // ---- decode back-pressure ----
      instr_ready = 1'b0;
      repeat (3) cycle();
      chkb("s_valid0", instr_valid, 1'b1);
      chk("s_pc0", instr_pc, 32'h14);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chkb("s_valid", instr_valid, 1'b1);
         chk("s_pc", instr_pc, 32'h14);
         chk("s_instr", instr, word_of(32'h14));
         chkb("s_req", imem_req, 1'b0);
      end
      instr_ready = 1'b1;
      cycle();
      chkb("s_resume_valid", instr_valid, 1'b0);
      chk("s_resume_addr", imem_addr, 32'h18);

      // ---- redirect while holding instruction at 0x8 ----
      lat = 1;
      instr_ready = 1'b0;
      cycle();
      chk("d_pc18", instr_pc, 32'h18);
      redirect = 1'b1; redirect_target = 32'h8;
      cycle();
      redirect = 1'b0;
      cycle();
      chkb("d_hold8", instr_valid, 1'b1);
      chk("d_pc8", instr_pc, 32'h8);
      redirect = 1'b1; redirect_target = 32'h0000_0103; instr_ready = 1'b1;
      cycle();
      redirect = 1'b0; instr_ready = 1'b0;
      chkb("d_squash", instr_valid, 1'b0);
      chk("d_addr", imem_addr, 32'h100);
      cycle();
      chk("d_pc100", instr_pc, 32'h100);

      // ---- redirect during a pending fetch at 0x10 ----
      redirect = 1'b1; redirect_target = 32'h10;
      cycle();
      redirect = 1'b0;
      lat = 3;
      redirect = 1'b1; redirect_target = 32'h40;
      cycle();
      redirect = 1'b0;
      chkb("e_req", imem_req, 1'b1);
      chk("e_addr1", imem_addr, 32'h10);
      cycle();
      chk("e_addr2", imem_addr, 32'h10);
      cycle();
      chkb("e_valid", instr_valid, 1'b0);
      chk("e_next", imem_addr, 32'h40);

      // ---- second redirect while draining a stale fetch ----
      redirect = 1'b1; redirect_target = 32'h60;
      cycle();
      redirect_target = 32'h80;
      cycle();
      redirect = 1'b0;
      chkb("f_req", imem_req, 1'b1);
      chk("f_addr", imem_addr, 32'h40);
      cycle();
      chk("f_next", imem_addr, 32'h80);
      lat = 1;
      cycle();
      chk("f_pc", instr_pc, 32'h80);
      chk("f_instr", instr, word_of(32'h80));

      // ---- reset in the middle of a wait ----
      instr_ready = 1'b1;
      lat = 3;
      cycle();
      cycle();
      chk("h_addr", imem_addr, 32'h84);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chkb("h_req", imem_req, 1'b0);
      chkb("h_valid", instr_valid, 1'b0);
      lat = 1;
      cycle();
      chk("h_refetch", imem_addr, 32'h0);
      cycle();
      chk("h_pc", instr_pc, 32'h0);

      // ---- randomized traffic against the model ----
      rnd_mem = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         instr_ready     = ($urandom_range(0, 2) != 0);
         redirect        = ($urandom_range(0, 9) == 0);
         redirect_target = $urandom();
         rst             = ($urandom_range(0, 199) == 0);
         cycle();
      end
      rst = 1'b0;
      redirect = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
